// File: rtl/tdc_pkg.sv
// Shared types and constants for the tapped-delay-line capture block.
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_HOLD
    } tdc_state_t;

    // Cycles spent flushing the two-flop tap synchronizer before sampling.
    localparam int SETTLE_LEN = 2;

    function automatic int count_width(input int n_taps);
        return $clog2(n_taps + 1);
    endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// Combinational thermometer-to-count decoder for synchronized delay-line taps.
// TDC_BUBBLE_FIX_EN selects the majority-filtered first-zero decoder; otherwise a popcount.
import tdc_pkg::*;

module tdc_therm2bin #(
    parameter int N_TAPS = 16,
    parameter int CW     = count_width(N_TAPS)
) (
    input  logic [N_TAPS-1:0] taps,
    output logic [CW-1:0]     count
);

`ifdef TDC_BUBBLE_FIX_EN
    // Pad below with 1 (edge always entered) and above with 0 (edge never left).
    logic [N_TAPS+1:0] ext;
    logic [N_TAPS-1:0] filt;

    assign ext = {1'b0, taps, 1'b1};

    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_maj
            assign filt[gi] = (ext[gi] & ext[gi+1]) |
                              (ext[gi] & ext[gi+2]) |
                              (ext[gi+1] & ext[gi+2]);
        end
    endgenerate

    always_comb begin
        count = CW'(N_TAPS);
        for (int i = N_TAPS - 1; i >= 0; i--) begin
            if (!filt[i]) begin
                count = CW'(i);
            end
        end
    end
`else
    always_comb begin
        count = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            count = count + CW'(taps[i]);
        end
    end
`endif

endmodule

// File: rtl/tdc_capture.sv
// Delay-line TDC capture: synchronizes taps, averages 2^LOG2_AVG decoded samples,
// and holds the result behind a valid/ready handshake. Optional macro: TDC_BUBBLE_FIX_EN.
import tdc_pkg::*;

module tdc_capture #(
    parameter int N_TAPS   = 16,
    parameter int LOG2_AVG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_TAPS-1:0] taps,
    input  logic              start,
    output logic              busy,
    output logic              meas_valid,
    input  logic              meas_ready,
    output logic [7:0]        meas_data,
    output logic [7:0]        last_count
);

    localparam int CW        = count_width(N_TAPS);
    localparam int AW        = CW + LOG2_AVG;
    localparam int PW        = LOG2_AVG + 2;
    localparam int N_SAMPLES = 1 << LOG2_AVG;

    tdc_state_t        state_reg, state_next;
    logic [PW-1:0]     phase_reg;
    logic [N_TAPS-1:0] sync1_reg, sync2_reg;
    logic [AW-1:0]     acc_reg;
    logic [7:0]        meas_data_reg;
    logic [7:0]        last_count_reg;
    logic [CW-1:0]     count;
    logic              sampling;
    logic              finishing;

    tdc_therm2bin #(
        .N_TAPS (N_TAPS),
        .CW     (CW)
    ) u_therm2bin (
        .taps  (sync2_reg),
        .count (count)
    );

    // ACCUM samples for N_SAMPLES cycles, then spends one more cycle dividing into meas_data.
    assign sampling  = (state_reg == ST_ACCUM) && (phase_reg != PW'(N_SAMPLES));
    assign finishing = (state_reg == ST_ACCUM) && (phase_reg == PW'(N_SAMPLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (phase_reg == PW'(SETTLE_LEN - 1)) state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (finishing) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (meas_ready) state_next = start ? ST_SETTLE : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg      <= '0;
            sync1_reg      <= '0;
            sync2_reg      <= '0;
            acc_reg        <= '0;
            meas_data_reg  <= '0;
            last_count_reg <= '0;
        end else begin
            sync1_reg <= taps;
            sync2_reg <= sync1_reg;

            if (state_next != state_reg) begin
                phase_reg <= '0;
            end else begin
                phase_reg <= phase_reg + PW'(1);
            end

            if (state_next == ST_SETTLE && state_reg != ST_SETTLE) begin
                acc_reg <= '0;
            end else if (sampling) begin
                acc_reg <= acc_reg + AW'(count);
            end

            if (sampling) begin
                last_count_reg <= 8'(count);
            end

            if (finishing) begin
                meas_data_reg <= 8'(acc_reg >> LOG2_AVG);
            end
        end
    end

    assign busy       = (state_reg != ST_IDLE);
    assign meas_valid = (state_reg == ST_HOLD);
    assign meas_data  = meas_data_reg;
    assign last_count = last_count_reg;

endmodule
